mul_scheduler: RTL and testbench

//  Shares one iterative repeated-add 8x8 multiplier between NREQ requesters.

---
 rtl/mul_sched_pkg.sv | 34 +++
 rtl/mul_engine.sv | 44 ++++
 rtl/mul_scheduler.sv | 93 +++++++++
 tb/tb_mul_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types, defaults and the round-robin pick helper for the multiply scheduler.
package mul_sched_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned MAX_NREQ  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    // First set request scanning upward from ptr, wrapping at n.
    function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_NREQ; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[4:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/mul_engine.sv
// Iterative repeated-add multiplier: loops over the smaller operand, adding the larger.
module mul_engine
    import mul_sched_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] add;
    logic [PW-1:0]    acc;
    logic             a_lt_b;

    assign a_lt_b = (a < b);

    // Decrement only while cnt is non-zero, so cnt never wraps and idles at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            add <= '0;
            acc <= '0;
        end else if (start) begin
            cnt <= a_lt_b ? a : b;
            add <= a_lt_b ? b : a;
            acc <= '0;
        end else if (cnt != '0) begin
            acc <= acc + PW'(add);
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign done    = (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/mul_scheduler.sv
// Round-robin front end sharing one mul_engine between NREQ requesters.
module mul_scheduler
    import mul_sched_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     a_in,
    input  logic [NREQ*WIDTH-1:0]     b_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      res_valid,
    output logic [2*WIDTH-1:0]        result,
    output logic [$clog2(NREQ)-1:0]   res_id
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned PW  = 2 * WIDTH;

    sched_state_t   state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] pick;
    logic           accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic           eng_done;
    logic [PW-1:0]  eng_product;

    assign pick   = IDW'(rr_pick(MAX_NREQ'(req), 32'(rr_ptr), NREQ));
    assign accept = (state == IDLE) && (|req);
    assign a_sel  = a_in[pick*WIDTH +: WIDTH];
    assign b_sel  = b_in[pick*WIDTH +: WIDTH];

    mul_engine #(.WIDTH(WIDTH)) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .a       (a_sel),
        .b       (b_sel),
        .done    (eng_done),
        .product (eng_product)
    );

    // Scheduler FSM; requests are only sampled in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            result    <= '0;
            res_id    <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt    <= NREQ'(1) << pick;
                        owner  <= pick;
                        rr_ptr <= (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        result    <= eng_product;
                        res_id    <= owner;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a result scoreboard checked by a separate monitor.
module tb_mul_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   a_in;
    logic [NREQ*WIDTH-1:0]   b_in;
    logic [NREQ-1:0]         gnt;
    logic                    busy;
    logic                    res_valid;
    logic [2*WIDTH-1:0]      result;
    logic [1:0]              res_id;

    int total = 0;
    int bad   = 0;
    int exp_res[$];
    int exp_id[$];

    mul_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .result    (result),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: every res_valid pops one expected result.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (exp_res.size() == 0) begin
                timeout("unexpected_res_valid");
            end else begin
                chk("result", int'(result), exp_res.pop_front());
                chk("res_id", int'(res_id), exp_id.pop_front());
            end
        end
    end

    task automatic set_ops(input int id, input int a, input int b);
        a_in[id*WIDTH +: WIDTH] = WIDTH'(a);
        b_in[id*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic expect_res(input int id, input int prod);
        exp_res.push_back(prod);
        exp_id.push_back(id);
    endtask

    task automatic wait_gnt(output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 400 && !ok) begin
            @(negedge clk);
            n++;
            if (gnt != '0) ok = 1'b1;
        end
        if (!ok) timeout("gnt_wait");
    endtask

    task automatic wait_res(input int exp_lat);
        int n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (n < 400 && !seen) begin
            @(negedge clk);
            n++;
            if (res_valid) seen = 1'b1;
        end
        if (!seen) timeout("res_wait");
        else chk("latency", n, exp_lat);
    endtask

    // Single requester op: request, check grant, drop request, check latency.
    task automatic single_op(input int id, input int a, input int b, input int prod, input int lat);
        logic ok;
        set_ops(id, a, b);
        req[id] = 1'b1;
        wait_gnt(ok);
        if (ok) begin
            chk("gnt_onehot", int'(gnt), 1 << id);
            chk("busy_run", int'(busy), 1);
            expect_res(id, prod);
        end
        req[id] = 1'b0;
        if (ok) wait_res(lat);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic ok;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        rst_n = 1'b0;

        // Reset values held across two reset cycles.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_res_valid", int'(res_valid), 0);
            chk("rst_result", int'(result), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        single_op(0, 20, 23, 460, 21);
        single_op(1, 200, 0, 0, 1);

        // Concurrent req[0] and req[2] with rr_ptr at 2: grant 2 then 0.
        set_ops(0, 3, 4);
        set_ops(2, 3, 4);
        req = 4'b0101;
        wait_gnt(ok);
        if (ok) begin
            chk("rr_first", int'(gnt), 4'b0100);
            expect_res(2, 12);
        end
        req[2] = 1'b0;
        wait_gnt(ok);
        if (ok) begin
            chk("rr_second", int'(gnt), 4'b0001);
            expect_res(0, 12);
        end
        req[0] = 1'b0;
        repeat (20) @(negedge clk);

        // All four held continuously after reset: grants 0,1,2,3,0.
        do_reset(2);
        set_ops(0, 1, 2);
        set_ops(1, 3, 5);
        set_ops(2, 6, 7);
        set_ops(3, 11, 10);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int id;
            int prods[4];
            prods = '{2, 15, 42, 110};
            id = g % 4;
            wait_gnt(ok);
            if (ok) begin
                chk("rr_all", int'(gnt), 1 << id);
                expect_res(id, prods[id]);
            end
        end
        req = '0;
        repeat (30) @(negedge clk);

        single_op(1, 255, 255, 65025, 256);

        // Reset five cycles into RUN aborts the op with no result.
        set_ops(0, 20, 23);
        req[0] = 1'b1;
        wait_gnt(ok);
        if (ok) chk("abort_gnt", int'(gnt), 4'b0001);
        req[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy_pre", int'(busy), 1);
        do_reset(1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        repeat (30) @(negedge clk);

        single_op(3, 7, 6, 42, 7);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_res.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
